rsa_modexp_engine: RTL and testbench
====================================

# rsa_modexp_engine

Parametrised modular-exponentiation engine computing result = message^exponent mod modulus for WIDTH-bit operands. It is the next generation of the team's 16-bit RSA block. It adds a start/done handshake, any operand width, and a bit-serial interleaved modular multiplier in place of wide multiply/`%` hardware. It also adds an optional constant-time mode that hides the exponent's Hamming weight and bit length. The engine sits between the key/message register file and the ciphertext output register, and serves both encrypt (e) and decrypt (d).

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 4
- CONST_TIME, 0, 1 = fixed schedule independent of exponent value; 0 = early-exit and skip multiplies for zero bits
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only while busy=0
- message  input  WIDTH  base; any value, including ≥ modulus
- exponent  input  WIDTH  exponent (e or d)
- modulus  input  WIDTH  modulus n
- busy  output  1  high from the accept edge until the edge that raises done
- done  output  1  one-cycle pulse when result/error are valid
- result  output  WIDTH  final value; holds until the next done
- error  output  1  set with done when modulus < 2; holds until the next done

## Operation
- Reset values: busy=0, done=0, result=0, error=0, state IDLE, all internal registers 0.
- IDLE:
  - When start=1, capture message, exponent and modulus into internal registers. Later input changes are ignored.
  - If modulus < 2, go to DONE with the error flag set.
  - Otherwise set acc=1, clear the iteration count and go to REDUCE.
- Modular multiply MM(a,b) (a any WIDTH value, b < n):
  - r=0; for i = WIDTH-1 down to 0, one bit per cycle: r=2r, subtract n if r ≥ n; if a[i], r=r+b, subtract n if r ≥ n.
  - Internal datapath is WIDTH+1 bits. Every MM takes exactly WIDTH cycles.
- REDUCE: base = MM(message, 1), i.e. message mod n. Then go to STEP.
- STEP (1 cycle):
  - Go to DONE if the remaining exponent is 0 (CONST_TIME=0) or the iteration count is WIDTH (CONST_TIME=1).
  - Otherwise go to MUL_R if exp[0]=1 or CONST_TIME=1, else go to MUL_B.
- MUL_R: t = MM(acc, base). acc=t only if exp[0]=1; in constant-time mode a zero bit discards t. Then go to MUL_B.
- MUL_B: base = MM(base, base). Then shift the exponent right by 1, increment the count and go to STEP.
- DONE (1 cycle):
  - Normal path: result=acc, error=0.
  - Error path: result=0, error=1.
  - In both cases done=1 for one cycle and the state returns to IDLE.
- start while busy=1 is ignored, with no queueing.
- start may be re-asserted in the cycle done is high. It is accepted on that edge, because busy is 0 in that cycle.
- Exponent 0 gives result=1 for any valid n, including message ≡ 0.
- Even moduli are legal; the modulus is not required to be odd.
- Asserting reset at any point returns everything to the reset values immediately. An in-flight operation is lost and gives no done pulse.

## Timing
- The accept edge is the rising edge where busy=0 and start=1. busy rises on that edge.
- Let L = bit length of the exponent (0 if exponent=0) and H = popcount(exponent).
- CONST_TIME=0: done rises WIDTH + L·(WIDTH+1) + H·WIDTH + 2 edges after the accept edge.
- CONST_TIME=1: done rises WIDTH + WIDTH·(2·WIDTH+1) + 2 edges after the accept edge, for every exponent.
- Error path: done rises 1 edge after the accept edge.
- busy falls on the same edge that done rises. done stays high for exactly 1 cycle.
- result and error change only on the edge that raises done.

## Test plan
- WIDTH=16, CONST_TIME=0: message=65, exponent=17, modulus=3233 → result=2790, error=0, done 135 edges after accept.
- Decrypt: message=2790, exponent=2753, modulus=3233 → result=65.
- Edge operands:
  - message=3298 (≥ n), exponent=17, modulus=3233 → result=2790.
  - exponent=0 → result=1, done 18 edges after accept.
- modulus=1, then modulus=0 → error=1, result=0, done 1 edge after accept. A following valid request clears error.
- Sequencing and reset:
  - Pulse start again mid-operation with different operands → ignored; the first result is unchanged.
  - Assert reset mid-operation → all outputs 0 and no done. The next request completes correctly.
- CONST_TIME=1 with exponents 17, 2753 and 0 → correct results (2790, 65 with the operands above; 1 for exponent 0). Every run gives done exactly 546 edges after accept.

Source files
------------

// File: rtl/rsa_modexp_engine_if.sv
// Request/response bundle for the modular-exponentiation engine.
// The master drives the operands and start; the slave returns busy, done, result and error.
interface rsa_modexp_engine_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] message;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             error;

  modport master (
    output start, message, exponent, modulus,
    input  busy, done, result, error
  );

  modport slave (
    input  start, message, exponent, modulus,
    output busy, done, result, error
  );
endinterface

// File: rtl/rsa_modexp_engine.sv
// Computes message^exponent mod modulus with a bit-serial interleaved modular multiplier.
// Right-to-left square-and-multiply, with an optional fixed-schedule (constant-time) mode.
module rsa_modexp_engine #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          CONST_TIME = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_modexp_engine_if.slave   bus
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_STEP,
    S_MUL_R,
    S_MUL_B,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] msg_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [DW-1:0]    r;
  logic [IW-1:0]    bit_idx;
  logic [CW-1:0]    iter;
  logic             err_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             error_q;

  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [DW-1:0]    n_ext;
  logic [DW-1:0]    r_dbl;
  logic [DW-1:0]    r_sub1;
  logic [DW-1:0]    r_add;
  logic [DW-1:0]    r_next;
  logic             mm_last;
  logic             step_finish;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.error  = error_q;

  // Multiplier operands are selected by the state so one datapath serves all three products.
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (state)
      S_REDUCE: begin
        mm_a = msg_q;
        mm_b = WIDTH'(1);
      end
      S_MUL_R: begin
        mm_a = acc;
        mm_b = base;
      end
      S_MUL_B: begin
        mm_a = base;
        mm_b = base;
      end
      default: begin
        mm_a = '0;
        mm_b = '0;
      end
    endcase
  end

  // One interleaved step: r stays below n, so 2r and r+b both fit in WIDTH+1 bits.
  always_comb begin
    n_ext       = {1'b0, mod_q};
    r_dbl       = r << 1;
    r_sub1      = (r_dbl >= n_ext) ? (r_dbl - n_ext) : r_dbl;
    r_add       = mm_a[bit_idx] ? (r_sub1 + {1'b0, mm_b}) : r_sub1;
    r_next      = (r_add >= n_ext) ? (r_add - n_ext) : r_add;
    mm_last     = (bit_idx == '0);
    step_finish = CONST_TIME ? (iter == CW'(WIDTH)) : (exp_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      msg_q    <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      acc      <= '0;
      base     <= '0;
      r        <= '0;
      bit_idx  <= '0;
      iter     <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            msg_q  <= bus.message;
            exp_q  <= bus.exponent;
            mod_q  <= bus.modulus;
            busy_q <= 1'b1;
            if (bus.modulus < WIDTH'(2)) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              acc     <= WIDTH'(1);
              iter    <= '0;
              r       <= '0;
              bit_idx <= IW'(WIDTH - 1);
              state   <= S_REDUCE;
            end
          end
        end

        S_REDUCE: begin
          if (mm_last) begin
            base    <= r_next[WIDTH-1:0];
            r       <= '0;
            bit_idx <= IW'(WIDTH - 1);
            state   <= S_STEP;
          end else begin
            r       <= r_next;
            bit_idx <= bit_idx - 1'b1;
          end
        end

        S_STEP: begin
          if (step_finish) begin
            state <= S_DONE;
          end else if (exp_q[0] || CONST_TIME) begin
            state <= S_MUL_R;
          end else begin
            state <= S_MUL_B;
          end
        end

        // In constant-time mode a zero exponent bit still runs the multiply but drops the product.
        S_MUL_R: begin
          if (mm_last) begin
            if (exp_q[0]) begin
              acc <= r_next[WIDTH-1:0];
            end
            r       <= '0;
            bit_idx <= IW'(WIDTH - 1);
            state   <= S_MUL_B;
          end else begin
            r       <= r_next;
            bit_idx <= bit_idx - 1'b1;
          end
        end

        S_MUL_B: begin
          if (mm_last) begin
            base    <= r_next[WIDTH-1:0];
            exp_q   <= exp_q >> 1;
            iter    <= iter + 1'b1;
            r       <= '0;
            bit_idx <= IW'(WIDTH - 1);
            state   <= S_STEP;
          end else begin
            r       <= r_next;
            bit_idx <= bit_idx - 1'b1;
          end
        end

        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (err_q) begin
            result_q <= '0;
            error_q  <= 1'b1;
          end else begin
            result_q <= acc;
            error_q  <= 1'b0;
          end
          err_q <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine: one variable-time and one constant-time instance.
// Expected results and done latencies are hand-computed from the operands.
module tb_rsa_modexp_engine;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rsa_modexp_engine_if #(.WIDTH(16)) ia ();
  rsa_modexp_engine_if #(.WIDTH(16)) ib ();

  rsa_modexp_engine #(.WIDTH(16), .CONST_TIME(1'b0)) dut_vt (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.slave)
  );

  rsa_modexp_engine #(.WIDTH(16), .CONST_TIME(1'b1)) dut_ct (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Issues one request and counts rising edges from the accept edge until done is seen.
  task automatic run(input bit ct, input logic [15:0] m, input logic [15:0] e,
                     input logic [15:0] n, output logic [15:0] res,
                     output logic err, output int lat);
    @(negedge clk);
    if (ct) begin
      ib.message = m; ib.exponent = e; ib.modulus = n; ib.start = 1'b1;
    end else begin
      ia.message = m; ia.exponent = e; ia.modulus = n; ia.start = 1'b1;
    end
    @(posedge clk);
    #1;
    ia.start = 1'b0;
    ib.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      #1;
      if (ct ? ib.done : ia.done) begin
        lat = c;
        break;
      end
    end
    res = ct ? ib.result : ia.result;
    err = ct ? ib.error : ia.error;
  endtask

  logic [15:0] res;
  logic        err;
  int          lat;
  int          pulses;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ia.start = 1'b0; ia.message = '0; ia.exponent = '0; ia.modulus = '0;
    ib.start = 1'b0; ib.message = '0; ib.exponent = '0; ib.modulus = '0;
    #12;
    check("rst_busy",   32'(ia.busy),   32'd0);
    check("rst_done",   32'(ia.done),   32'd0);
    check("rst_result", 32'(ia.result), 32'd0);
    check("rst_error",  32'(ia.error),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(1'b0, 16'd65, 16'd17, 16'd3233, res, err, lat);
    check("enc_result", 32'(res), 32'd2790);
    check("enc_error",  32'(err), 32'd0);
    check("enc_lat",    32'(lat), 32'd135);
    @(posedge clk);
    #1;
    check("done_pulse", 32'(ia.done), 32'd0);
    check("busy_idle",  32'(ia.busy), 32'd0);
    check("res_hold",   32'(ia.result), 32'd2790);

    run(1'b0, 16'd2790, 16'd2753, 16'd3233, res, err, lat);
    check("dec_result", 32'(res), 32'd65);
    check("dec_lat",    32'(lat), 32'd302);

    run(1'b0, 16'd3298, 16'd17, 16'd3233, res, err, lat);
    check("bigmsg_result", 32'(res), 32'd2790);

    run(1'b0, 16'd0, 16'd0, 16'd3233, res, err, lat);
    check("exp0_result", 32'(res), 32'd1);
    check("exp0_lat",    32'(lat), 32'd18);

    run(1'b0, 16'd0, 16'd5, 16'd7, res, err, lat);
    check("msg0_result", 32'(res), 32'd0);
    check("msg0_lat",    32'(lat), 32'd101);

    run(1'b0, 16'd65, 16'd17, 16'd1, res, err, lat);
    check("mod1_result", 32'(res), 32'd0);
    check("mod1_error",  32'(err), 32'd1);
    check("mod1_lat",    32'(lat), 32'd1);

    run(1'b0, 16'd65, 16'd17, 16'd0, res, err, lat);
    check("mod0_result", 32'(res), 32'd0);
    check("mod0_error",  32'(err), 32'd1);
    check("mod0_lat",    32'(lat), 32'd1);

    run(1'b0, 16'd65, 16'd17, 16'd3233, res, err, lat);
    check("clr_error",  32'(err), 32'd0);
    check("clr_result", 32'(res), 32'd2790);

    run(1'b0, 16'd3, 16'd4, 16'd10, res, err, lat);
    check("even_result", 32'(res), 32'd1);
    check("even_lat",    32'(lat), 32'd85);

    // Second start mid-operation must be ignored; result holds the previous value meanwhile.
    @(negedge clk);
    ia.message = 16'd65; ia.exponent = 16'd17; ia.modulus = 16'd3233; ia.start = 1'b1;
    @(posedge clk);
    #1;
    ia.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      #1;
      if (c == 20) begin
        check("busy_mid", 32'(ia.busy),   32'd1);
        check("hold_mid", 32'(ia.result), 32'd1);
        ia.message = 16'd2790; ia.exponent = 16'd2753; ia.modulus = 16'd3000; ia.start = 1'b1;
      end
      if (c == 21) ia.start = 1'b0;
      if (ia.done) begin
        lat = c;
        break;
      end
    end
    check("ignore_result", 32'(ia.result), 32'd2790);
    check("ignore_lat",    32'(lat),       32'd135);

    // Reset mid-operation clears outputs and suppresses done.
    @(negedge clk);
    ia.message = 16'd2790; ia.exponent = 16'd2753; ia.modulus = 16'd3233; ia.start = 1'b1;
    @(posedge clk);
    #1;
    ia.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_busy",   32'(ia.busy),   32'd0);
    check("rstmid_done",   32'(ia.done),   32'd0);
    check("rstmid_result", 32'(ia.result), 32'd0);
    check("rstmid_error",  32'(ia.error),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 320; c++) begin
      @(posedge clk);
      #1;
      if (ia.done) pulses++;
    end
    check("rstmid_nodone", 32'(pulses), 32'd0);
    run(1'b0, 16'd65, 16'd17, 16'd3233, res, err, lat);
    check("post_rst_result", 32'(res), 32'd2790);
    check("post_rst_lat",    32'(lat), 32'd135);

    run(1'b1, 16'd65, 16'd17, 16'd3233, res, err, lat);
    check("ct_enc_result", 32'(res), 32'd2790);
    check("ct_enc_lat",    32'(lat), 32'd546);

    run(1'b1, 16'd2790, 16'd2753, 16'd3233, res, err, lat);
    check("ct_dec_result", 32'(res), 32'd65);
    check("ct_dec_lat",    32'(lat), 32'd546);

    run(1'b1, 16'd65, 16'd0, 16'd3233, res, err, lat);
    check("ct_exp0_result", 32'(res), 32'd1);
    check("ct_exp0_lat",    32'(lat), 32'd546);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
